uart_dr_fifo_ctrl: RTL and testbench

- Data-register backend of the UART, directly downstream of the APB interface stage.
- Consumes the DR/RSR write and read enables plus write data, and buffers TX bytes in a TX FIFO drained by the transmitter over a valid/ready handshake.
- Buffers received bytes with per-byte error bits in an RX FIFO drained by APB reads of DR.
- Produces DR read data, RSR status and FIFO flags for the flag register.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync_fifo.sv | 60 ++++++
 rtl/uart_dr_fifo_ctrl.sv | 122 ++++++++++++
 tb/tb_uart_dr_fifo_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART data-register backend.
package uart_pkg;

  localparam int UART_FIFO_DEPTH = 16;

  // Bit positions inside the receive status register.
  localparam int RSR_FE = 0;
  localparam int RSR_PE = 1;
  localparam int RSR_BE = 2;
  localparam int RSR_OE = 3;

  // One received character with its per-byte error bits.
  typedef struct packed {
    logic       be;
    logic       pe;
    logic       fe;
    logic [7:0] data;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a run-time capacity limit (cap <= DEPTH).
// Pointers wrap modulo DEPTH; a separate count keeps full/empty unambiguous.
module uart_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic [AW:0]      cap,
  output logic             push_acc,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      cnt_nxt;
  logic             pop_ok;

  // A pop on an empty FIFO is ignored. A push is taken when below the
  // capacity, or when exactly at it and a pop frees a slot this cycle.
  // If the capacity shrank below the current count, pushes wait until the
  // backlog drains under the new limit.
  assign pop_ok   = pop && (count != '0);
  assign push_acc = push && ((count < cap) || (pop_ok && (count <= cap)));
  assign cnt_nxt  = count + (AW+1)'(push_acc) - (AW+1)'(pop_ok);

  // Pointers, count and flags; flags come from the next-state count so they
  // line up with the count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)   rd_ptr <= rd_ptr + AW'(1);
      count <= cnt_nxt;
      full  <= (cnt_nxt >= cap);
      empty <= (cnt_nxt == '0);
    end
  end

  // Storage is deliberately not reset; its contents are masked while empty.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/uart_dr_fifo_ctrl.sv
// UART data-register backend: TX/RX FIFOs behind the APB DR, RSR status,
// FIFO flags and the registered busy indication.
module uart_dr_fifo_ctrl
  import uart_pkg::*;
#(
  parameter  int DEPTH = UART_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [31:0] wdata_i,
  input  logic        penable_i,
  input  logic        dr_wren_i,
  input  logic        dr_rden_i,
  input  logic        rsr_wren_i,
  input  logic        fen_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  input  logic        tx_busy_i,
  input  logic        rx_push_i,
  input  logic [7:0]  rx_data_i,
  input  logic [2:0]  rx_err_i,
  output logic [31:0] rdata_o,
  output logic [3:0]  rsr_o,
  output logic        txff_o,
  output logic        txfe_o,
  output logic        rxff_o,
  output logic        rxfe_o,
  output logic        busy_o
);

  logic [AW:0]    cap;
  logic           tx_pop;
  logic [7:0]     tx_head;
  logic           tx_acc;
  logic [AW:0]    tx_cnt;
  logic           rx_pop;
  logic           rx_acc;
  logic [AW:0]    rx_cnt;
  logic           overrun;
  uart_rx_entry_t rx_in;
  uart_rx_entry_t rx_head;
  logic           unused_bits;

  // With the FIFOs disabled each side degenerates to a one-entry holding reg.
  assign cap = fen_i ? (AW+1)'(DEPTH) : (AW+1)'(1);

  assign tx_pop = tx_valid_o && tx_ready_i;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk      (pclk),
    .rst_n    (presetn),
    .push     (dr_wren_i),
    .din      (wdata_i[7:0]),
    .pop      (tx_pop),
    .cap      (cap),
    .push_acc (tx_acc),
    .full     (txff_o),
    .empty    (txfe_o),
    .count    (tx_cnt),
    .head     (tx_head)
  );

  // Head byte is forced to zero while empty so stale storage never leaks.
  assign tx_valid_o = !txfe_o;
  assign tx_data_o  = txfe_o ? 8'h00 : tx_head;

  assign rx_in = '{be: rx_err_i[2], pe: rx_err_i[1], fe: rx_err_i[0], data: rx_data_i};

  // One pop per APB read, taken at the end of the access phase.
  assign rx_pop = dr_rden_i && penable_i && !rxfe_o;

  uart_sync_fifo #(.WIDTH($bits(uart_rx_entry_t)), .DEPTH(DEPTH)) u_rx_fifo (
    .clk      (pclk),
    .rst_n    (presetn),
    .push     (rx_push_i),
    .din      (rx_in),
    .pop      (rx_pop),
    .cap      (cap),
    .push_acc (rx_acc),
    .full     (rxff_o),
    .empty    (rxfe_o),
    .count    (rx_cnt),
    .head     (rx_head)
  );

  // A character the RX FIFO could not take is an overrun.
  assign overrun = rx_push_i && !rx_acc;

  // Read data is held for the whole setup+access window of a DR read.
  assign rdata_o = (dr_rden_i && !rxfe_o) ? {21'h0, rx_head} : 32'h0;

  // RSR: popped error bits win over a clear; a new overrun wins over a clear.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rsr_o <= 4'h0;
    end else begin
      if (rx_pop) begin
        rsr_o[RSR_BE] <= rx_head.be;
        rsr_o[RSR_PE] <= rx_head.pe;
        rsr_o[RSR_FE] <= rx_head.fe;
      end else if (rsr_wren_i) begin
        rsr_o[RSR_BE] <= 1'b0;
        rsr_o[RSR_PE] <= 1'b0;
        rsr_o[RSR_FE] <= 1'b0;
      end
      if (overrun)         rsr_o[RSR_OE] <= 1'b1;
      else if (rsr_wren_i) rsr_o[RSR_OE] <= 1'b0;
    end
  end

  // Busy follows pending TX data or an active shifter, one cycle later.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) busy_o <= 1'b0;
    else          busy_o <= !txfe_o || tx_busy_i;
  end

  // Upper write-data bits and the raw counts are not needed here.
  assign unused_bits = ^{wdata_i[31:8], tx_acc, tx_cnt, rx_cnt};

endmodule

// File: tb/tb_uart_dr_fifo_ctrl.sv
// Bench for uart_dr_fifo_ctrl: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_uart_dr_fifo_ctrl;

  localparam int DEPTH = 16;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [31:0] wdata_i;
  logic        penable_i, dr_wren_i, dr_rden_i, rsr_wren_i, fen_i;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i, tx_busy_i, rx_push_i;
  logic [7:0]  rx_data_i;
  logic [2:0]  rx_err_i;
  logic [31:0] rdata_o;
  logic [3:0]  rsr_o;
  logic        txff_o, txfe_o, rxff_o, rxfe_o, busy_o;

  always #5 pclk = ~pclk;

  uart_dr_fifo_ctrl #(.DEPTH(DEPTH)) dut (
    .pclk(pclk), .presetn(presetn), .wdata_i(wdata_i), .penable_i(penable_i),
    .dr_wren_i(dr_wren_i), .dr_rden_i(dr_rden_i), .rsr_wren_i(rsr_wren_i),
    .fen_i(fen_i), .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o),
    .tx_ready_i(tx_ready_i), .tx_busy_i(tx_busy_i), .rx_push_i(rx_push_i),
    .rx_data_i(rx_data_i), .rx_err_i(rx_err_i), .rdata_o(rdata_o),
    .rsr_o(rsr_o), .txff_o(txff_o), .txfe_o(txfe_o), .rxff_o(rxff_o),
    .rxfe_o(rxfe_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wdata_i = '0; penable_i = 0; dr_wren_i = 0; dr_rden_i = 0; rsr_wren_i = 0;
    tx_ready_i = 0; tx_busy_i = 0; rx_push_i = 0; rx_data_i = '0; rx_err_i = '0;
  endtask

  task automatic tick();
    @(posedge pclk); #1;
  endtask

  task automatic do_reset();
    idle();
    presetn = 0;
    repeat (2) @(posedge pclk);
    #1 presetn = 1;
  endtask

  // Each row: inputs held for one cycle; expected outputs sampled before the edge.
  typedef struct {
    logic wr; logic [7:0] wd; logic rd, pen, rxp; logic [7:0] rxd; logic [2:0] rxe;
    logic rsrw, rdy, tbusy;
    logic vld; logic [7:0] txd; logic txfe, txff, rxfe, rxff; logic [3:0] rsr;
    logic [31:0] rdat; logic busy;
  } vec_t;
  vec_t vecs[$];

  // Reference model state.
  logic [7:0]  txq[$];
  logic [10:0] rxq[$];
  logic [3:0]  rsr_m;
  logic        busy_m;
  int          cap_last, cap, ts, rs, rd_phase;
  logic        tpop, tpush, rpop, rpush;
  logic [10:0] popped;

  task automatic model_check(input int cyc);
    chk($sformatf("rnd%0d_vld", cyc), {31'h0, tx_valid_o}, {31'h0, txq.size() > 0});
    chk($sformatf("rnd%0d_txd", cyc), {24'h0, tx_data_o}, txq.size() > 0 ? {24'h0, txq[0]} : 32'h0);
    chk($sformatf("rnd%0d_txfe", cyc), {31'h0, txfe_o}, {31'h0, txq.size() == 0});
    chk($sformatf("rnd%0d_txff", cyc), {31'h0, txff_o}, {31'h0, txq.size() >= cap_last});
    chk($sformatf("rnd%0d_rxfe", cyc), {31'h0, rxfe_o}, {31'h0, rxq.size() == 0});
    chk($sformatf("rnd%0d_rxff", cyc), {31'h0, rxff_o}, {31'h0, rxq.size() >= cap_last});
    chk($sformatf("rnd%0d_rsr", cyc), {28'h0, rsr_o}, {28'h0, rsr_m});
    chk($sformatf("rnd%0d_rdata", cyc), rdata_o,
        (dr_rden_i && rxq.size() > 0) ? {21'h0, rxq[0]} : 32'h0);
    chk($sformatf("rnd%0d_busy", cyc), {31'h0, busy_o}, {31'h0, busy_m});
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    cap   = fen_i ? DEPTH : 1;
    ts    = txq.size();
    rs    = rxq.size();
    tpop  = (ts > 0) && tx_ready_i;
    tpush = dr_wren_i && ((ts < cap) || (tpop && ts <= cap));
    rpop  = dr_rden_i && penable_i && (rs > 0);
    rpush = rx_push_i && ((rs < cap) || (rpop && rs <= cap));
    popped = (rs > 0) ? rxq[0] : 11'h0;
    if (tpop)  void'(txq.pop_front());
    if (tpush) txq.push_back(wdata_i[7:0]);
    if (rpop)  void'(rxq.pop_front());
    if (rpush) rxq.push_back({rx_err_i, rx_data_i});
    if (rpop) rsr_m[2:0] = popped[10:8];
    else if (rsr_wren_i) rsr_m[2:0] = 3'b000;
    if (rx_push_i && !rpush) rsr_m[3] = 1'b1;
    else if (rsr_wren_i) rsr_m[3] = 1'b0;
    busy_m   = (ts > 0) || tx_busy_i;
    cap_last = cap;
  endtask

  initial begin
    fen_i = 1;
    do_reset();

    //             wr wd     rd pen rxp rxd    rxe   rsrw rdy tb | vld txd  tfe tff rfe rff rsr   rdat        busy
    vecs.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 3'd0, 0, 0, 0,  0, 8'h00, 1, 0, 1, 0, 4'h0, 32'h000, 0});
    vecs.push_back('{0, 8'h00, 1, 1, 0, 8'h00, 3'd0, 0, 0, 0,  0, 8'h00, 1, 0, 1, 0, 4'h0, 32'h000, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 1, 8'hA5, 3'd1, 0, 0, 0,  0, 8'h00, 1, 0, 1, 0, 4'h0, 32'h000, 0});
    vecs.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 3'd0, 0, 0, 0,  0, 8'h00, 1, 0, 0, 0, 4'h0, 32'h1A5, 0});
    vecs.push_back('{0, 8'h00, 1, 1, 0, 8'h00, 3'd0, 0, 0, 0,  0, 8'h00, 1, 0, 0, 0, 4'h0, 32'h1A5, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0,  0, 8'h00, 1, 0, 1, 0, 4'h1, 32'h000, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 3'd0, 1, 0, 0,  0, 8'h00, 1, 0, 1, 0, 4'h1, 32'h000, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0,  0, 8'h00, 1, 0, 1, 0, 4'h0, 32'h000, 0});
    vecs.push_back('{1, 8'h3C, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0,  0, 8'h00, 1, 0, 1, 0, 4'h0, 32'h000, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0,  1, 8'h3C, 0, 0, 1, 0, 4'h0, 32'h000, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 3'd0, 0, 1, 0,  1, 8'h3C, 0, 0, 1, 0, 4'h0, 32'h000, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0,  0, 8'h00, 1, 0, 1, 0, 4'h0, 32'h000, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 3'd0, 0, 0, 1,  0, 8'h00, 1, 0, 1, 0, 4'h0, 32'h000, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0,  0, 8'h00, 1, 0, 1, 0, 4'h0, 32'h000, 1});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0,  0, 8'h00, 1, 0, 1, 0, 4'h0, 32'h000, 0});
    vecs.push_back('{0, 8'h00, 1, 0, 1, 8'h5A, 3'd6, 0, 0, 0,  0, 8'h00, 1, 0, 1, 0, 4'h0, 32'h000, 0});
    vecs.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 3'd0, 0, 0, 0,  0, 8'h00, 1, 0, 0, 0, 4'h0, 32'h65A, 0});
    vecs.push_back('{0, 8'h00, 1, 1, 0, 8'h00, 3'd0, 1, 0, 0,  0, 8'h00, 1, 0, 0, 0, 4'h0, 32'h65A, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0,  0, 8'h00, 1, 0, 1, 0, 4'h6, 32'h000, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 3'd0, 1, 0, 0,  0, 8'h00, 1, 0, 1, 0, 4'h6, 32'h000, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 3'd0, 0, 0, 0,  0, 8'h00, 1, 0, 1, 0, 4'h0, 32'h000, 0});

    foreach (vecs[i]) begin
      dr_wren_i = vecs[i].wr;   wdata_i = {24'h0, vecs[i].wd};
      dr_rden_i = vecs[i].rd;   penable_i = vecs[i].pen;
      rx_push_i = vecs[i].rxp;  rx_data_i = vecs[i].rxd; rx_err_i = vecs[i].rxe;
      rsr_wren_i = vecs[i].rsrw; tx_ready_i = vecs[i].rdy; tx_busy_i = vecs[i].tbusy;
      #3;
      chk($sformatf("v%0d_vld", i),  {31'h0, tx_valid_o}, {31'h0, vecs[i].vld});
      chk($sformatf("v%0d_txd", i),  {24'h0, tx_data_o}, {24'h0, vecs[i].txd});
      chk($sformatf("v%0d_txfe", i), {31'h0, txfe_o}, {31'h0, vecs[i].txfe});
      chk($sformatf("v%0d_txff", i), {31'h0, txff_o}, {31'h0, vecs[i].txff});
      chk($sformatf("v%0d_rxfe", i), {31'h0, rxfe_o}, {31'h0, vecs[i].rxfe});
      chk($sformatf("v%0d_rxff", i), {31'h0, rxff_o}, {31'h0, vecs[i].rxff});
      chk($sformatf("v%0d_rsr", i),  {28'h0, rsr_o}, {28'h0, vecs[i].rsr});
      chk($sformatf("v%0d_rdata", i), rdata_o, vecs[i].rdat);
      chk($sformatf("v%0d_busy", i), {31'h0, busy_o}, {31'h0, vecs[i].busy});
      tick();
    end
    idle();

    // TX fill past capacity, then drain in order.
    for (int i = 0; i < 17; i++) begin
      dr_wren_i = 1; wdata_i = i;
      tick();
      if (i == 14) chk("txff_at_15", {31'h0, txff_o}, 32'h0);
      if (i == 15) chk("txff_at_16", {31'h0, txff_o}, 32'h1);
    end
    dr_wren_i = 0;
    chk("txff_after_17", {31'h0, txff_o}, 32'h1);
    tx_ready_i = 1;
    for (int k = 0; k < 16; k++) begin
      #3;
      chk($sformatf("drain%0d_vld", k), {31'h0, tx_valid_o}, 32'h1);
      chk($sformatf("drain%0d_data", k), {24'h0, tx_data_o}, k);
      tick();
    end
    tx_ready_i = 0;
    chk("drain_txfe", {31'h0, txfe_o}, 32'h1);
    chk("drain_vld", {31'h0, tx_valid_o}, 32'h0);

    // RX overrun, clear-vs-overrun priority, then read everything back.
    for (int i = 0; i < 17; i++) begin
      rx_push_i = 1; rx_data_i = i + 1; rx_err_i = 0;
      tick();
      if (i == 15) begin
        chk("rxff_at_16", {31'h0, rxff_o}, 32'h1);
        chk("oe_at_16", {28'h0, rsr_o}, 32'h0);
      end
    end
    chk("rxff_after_17", {31'h0, rxff_o}, 32'h1);
    chk("oe_after_17", {28'h0, rsr_o}, 32'h8);
    rx_data_i = 8'hEE; rsr_wren_i = 1;
    tick();
    chk("oe_clear_vs_overrun", {28'h0, rsr_o}, 32'h8);
    rx_push_i = 0;
    tick();
    rsr_wren_i = 0;
    chk("oe_cleared", {28'h0, rsr_o}, 32'h0);
    for (int k = 0; k < 16; k++) begin
      dr_rden_i = 1; penable_i = 0; #3;
      chk($sformatf("rd%0d_setup", k), rdata_o, k + 1);
      tick();
      penable_i = 1; #3;
      chk($sformatf("rd%0d_access", k), rdata_o, k + 1);
      tick();
    end
    dr_rden_i = 0; penable_i = 0;
    chk("rx_all_read", {31'h0, rxfe_o}, 32'h1);

    // Holding-register mode.
    fen_i = 0;
    dr_wren_i = 1; wdata_i = 32'h11; tick();
    chk("hold_full", {31'h0, txff_o}, 32'h1);
    wdata_i = 32'h22; tick();
    chk("hold_drop", {24'h0, tx_data_o}, 32'h11);
    wdata_i = 32'h33; tx_ready_i = 1; tick();
    chk("hold_swap_data", {24'h0, tx_data_o}, 32'h33);
    chk("hold_swap_full", {31'h0, txff_o}, 32'h1);
    dr_wren_i = 0; tick();
    tx_ready_i = 0;
    chk("hold_drained", {31'h0, txfe_o}, 32'h1);

    // Asynchronous reset in the middle of traffic.
    fen_i = 1;
    for (int i = 0; i < 3; i++) begin
      dr_wren_i = 1; wdata_i = 32'hA1 + i; tick();
    end
    dr_wren_i = 0;
    chk("pre_reset_vld", {31'h0, tx_valid_o}, 32'h1);
    #2 presetn = 0;
    #1;
    chk("reset_vld", {31'h0, tx_valid_o}, 32'h0);
    chk("reset_txfe", {31'h0, txfe_o}, 32'h1);
    chk("reset_txd", {24'h0, tx_data_o}, 32'h0);
    tick();
    presetn = 1; tx_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_reset%0d_vld", i), {31'h0, tx_valid_o}, 32'h0);
    end

    // Randomized traffic against the reference model.
    do_reset();
    txq.delete(); rxq.delete();
    rsr_m = 0; busy_m = 0; cap_last = DEPTH; rd_phase = 0; fen_i = 1;
    for (int c = 0; c < 3000; c++) begin
      if (rd_phase == 1) begin
        dr_rden_i = 1; penable_i = 1; rd_phase = 0;
      end else if ($urandom % 4 == 0) begin
        dr_rden_i = 1; penable_i = 0; rd_phase = 1;
      end else begin
        dr_rden_i = 0; penable_i = 0;
      end
      dr_wren_i  = !dr_rden_i && ($urandom % 3 == 0);
      wdata_i    = $urandom;
      rx_push_i  = ($urandom % 3 == 0);
      rx_data_i  = $urandom;
      rx_err_i   = $urandom;
      rsr_wren_i = ($urandom % 16 == 0);
      tx_ready_i = ($urandom % 2 == 0);
      tx_busy_i  = ($urandom % 4 == 0);
      if ($urandom % 300 == 0) fen_i = !fen_i;
      #3;
      model_check(c);
      model_edge();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
